// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between NUM_PORTS
// requesters (e.g. instruction and data ports of the multicycle core).
// One transaction is in flight at a time. The downstream request is
// registered, and completion is returned to the granted port as a
// one-cycle pulse.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins). Without it, arbitration is round-robin.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              port_read,
  input  logic [NUM_PORTS-1:0]              port_write,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0]   port_byte_enable,
  input  logic [NUM_PORTS*ADDR_W-1:0]       port_address,
  input  logic [NUM_PORTS*DATA_W-1:0]       port_wdata,
  output logic [NUM_PORTS*DATA_W-1:0]       port_rdata,
  output logic [NUM_PORTS-1:0]              port_resp,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [DATA_W/8-1:0]               mem_byte_enable,
  output logic [ADDR_W-1:0]                 mem_address,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_resp
);

  localparam int BE_W = DATA_W / 8;
  localparam int GW   = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_anyReq;
  logic [GW-1:0]         w_grant;

  logic                  w_selWrite;
  logic [BE_W-1:0]       w_selBe;
  logic [ADDR_W-1:0]     w_selAddr;
  logic [DATA_W-1:0]     w_selWdata;

  logic [GW-1:0]         r_grant;
  logic                  r_memRead;
  logic                  r_memWrite;
  logic [BE_W-1:0]       r_memBe;
  logic [ADDR_W-1:0]     r_memAddr;
  logic [DATA_W-1:0]     r_memWdata;
  logic [NUM_PORTS-1:0]  r_portResp;
  logic [DATA_W-1:0]     r_rdata [NUM_PORTS];

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [GW-1:0]         r_lastGrant;
  logic [GW-1:0]         w_grantHigh;
  logic [GW-1:0]         w_grantLow;
  logic                  w_foundHigh;
  logic                  w_foundLow;
`endif

  // A port requests when either strobe is set (a write takes precedence)
  always_comb begin
    w_req    = port_read | port_write;
    w_anyReq = |w_req;
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins
  always_comb begin
    w_grant = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_req[i]) w_grant = GW'(i);
    end
  end
`else
  // Round-robin: first requester above the last grant, else wrap to the lowest
  always_comb begin
    w_grantHigh = '0;
    w_grantLow  = '0;
    w_foundHigh = 1'b0;
    w_foundLow  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_req[i]) begin
        if (i > int'(r_lastGrant)) begin
          if (!w_foundHigh) begin
            w_grantHigh = GW'(i);
            w_foundHigh = 1'b1;
          end
        end else if (!w_foundLow) begin
          w_grantLow = GW'(i);
          w_foundLow = 1'b1;
        end
      end
    end
    w_grant = w_foundHigh ? w_grantHigh : w_grantLow;
  end
`endif

  // Select the winning port's request fields
  always_comb begin
    w_selWrite = 1'b0;
    w_selBe    = '0;
    w_selAddr  = '0;
    w_selWdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(w_grant) == i) begin
        w_selWrite = port_write[i];
        w_selBe    = port_byte_enable[i*BE_W +: BE_W];
        w_selAddr  = port_address[i*ADDR_W +: ADDR_W];
        w_selWdata = port_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state: IDLE -> BUSY on a request, BUSY -> RESP on mem_resp, RESP -> IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = BUSY;
      BUSY:    if (mem_resp) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Registered downstream request, grant tracking, read data and resp pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_lastGrant <= GW'(NUM_PORTS - 1);
`endif
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_memBe    <= '0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_portResp <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_rdata[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grant    <= w_grant;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_lastGrant <= w_grant;
`endif
            r_memWrite <= w_selWrite;
            r_memRead  <= !w_selWrite;
            r_memBe    <= w_selWrite ? w_selBe : {BE_W{1'b1}};
            r_memAddr  <= w_selAddr;
            r_memWdata <= w_selWdata;
          end else begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
              r_portResp[i] <= (int'(r_grant) == i);
              if (r_memRead && int'(r_grant) == i) r_rdata[i] <= mem_rdata;
            end
          end
        end
        default: begin
          r_portResp <= '0;
        end
      endcase
    end
  end

  // Drive outputs straight from registers
  always_comb begin
    mem_read        = r_memRead;
    mem_write       = r_memWrite;
    mem_byte_enable = r_memBe;
    mem_address     = r_memAddr;
    mem_wdata       = r_memWdata;
    port_resp       = r_portResp;
    for (int i = 0; i < NUM_PORTS; i++) port_rdata[i*DATA_W +: DATA_W] = r_rdata[i];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and a memory responder, with a
// transaction-level arbiter model feeding expected downstream requests and
// expected port responses into queues consumed by independent monitors.
module tb_mem_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int FW = 2 + BW + AW + DW;
  localparam int RW = NP * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]    port_read = '0;
  logic [NP-1:0]    port_write = '0;
  logic [NP*BW-1:0] port_byte_enable = '0;
  logic [NP*AW-1:0] port_address = '0;
  logic [NP*DW-1:0] port_wdata = '0;
  logic [RW-1:0]    port_rdata;
  logic [NP-1:0]    port_resp;
  logic             mem_read;
  logic             mem_write;
  logic [BW-1:0]    mem_byte_enable;
  logic [AW-1:0]    mem_address;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata = '0;
  logic             mem_resp = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .port_read(port_read), .port_write(port_write),
    .port_byte_enable(port_byte_enable), .port_address(port_address),
    .port_wdata(port_wdata), .port_rdata(port_rdata), .port_resp(port_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct { logic [FW-1:0] fields; int t; } txn_t;
  typedef struct { int port; logic [RW-1:0] rdata; int t; } resp_t;

  txn_t  expTxnQ[$];
  resp_t expRespQ[$];
  int    nChecks = 0;
  int    nErrors = 0;
  int    cyc = 0;

  // requester state
  bit            pend [NP];
  bit            pRd  [NP];
  bit            pWr  [NP];
  logic [AW-1:0] pAddr [NP];
  logic [BW-1:0] pBe   [NP];
  logic [DW-1:0] pWdata [NP];

  // memory responder and arbiter model state
  bit            memRespDrv = 1'b0;
  logic [DW-1:0] memRdataDrv = '0;
  int            mState = 0;
  int            mGrant = 0;
  int            mLast = NP - 1;
  int            busyCnt = 0;
  logic [DW-1:0] mRdata [NP];

  // knobs
  int reqPct = 0;
  int portMask = 0;
  int maxLat = 0;
  int spurPct = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportMiss(input string name, input int t);
    nChecks++;
    nErrors++;
    $display("[TB] FAIL %s: nothing observed, required at cycle %0d (now %0d)", name, t, cyc);
  endtask

  function automatic logic [RW-1:0] packRdata();
    logic [RW-1:0] v;
    for (int i = 0; i < NP; i++) v[i*DW +: DW] = mRdata[i];
    return v;
  endfunction

  function automatic int pickGrant();
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NP; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= NP; k++) if (pend[(mLast + k) % NP]) return (mLast + k) % NP;
`endif
    return -1;
  endfunction

  function automatic bit anyPend();
    for (int i = 0; i < NP; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // called at negedge: new requests, hold old ones, memory response
  task automatic applyStimulus();
    int kind;
    for (int i = 0; i < NP; i++) begin
      if (!pend[i] && ((portMask >> i) & 1) == 1 && int'($urandom_range(99, 0)) < reqPct) begin
        kind      = int'($urandom_range(3, 0));
        pRd[i]    = (kind != 2);
        pWr[i]    = (kind >= 2);
        pAddr[i]  = $urandom() & 32'hFFFF_FFFC;
        pBe[i]    = BW'($urandom());
        pWdata[i] = $urandom();
        pend[i]   = 1'b1;
      end
      port_read[i]                 = pend[i] && pRd[i];
      port_write[i]                = pend[i] && pWr[i];
      port_address[i*AW +: AW]     = pAddr[i];
      port_byte_enable[i*BW +: BW] = pBe[i];
      port_wdata[i*DW +: DW]       = pWdata[i];
    end
    if (mState == 1) begin
      memRespDrv = (busyCnt == 0);
      busyCnt--;
    end else begin
      memRespDrv = (int'($urandom_range(99, 0)) < spurPct);
    end
    memRdataDrv = $urandom();
    mem_resp    = memRespDrv;
    mem_rdata   = memRdataDrv;
  endtask

  // called at posedge: transaction-level arbiter behaviour
  task automatic modelStep();
    int    g;
    txn_t  tx;
    resp_t rs;
    cyc++;
    case (mState)
      0: begin
        g = pickGrant();
        if (g >= 0) begin
          tx.fields = {pWr[g], ~pWr[g], (pWr[g] ? pBe[g] : {BW{1'b1}}), pAddr[g], pWdata[g]};
          tx.t = cyc;
          expTxnQ.push_back(tx);
          mGrant = g;
`ifndef MEM_ARB_FIXED_PRIO_EN
          mLast = g;
`endif
          busyCnt = int'($urandom_range(maxLat, 0));
          mState = 1;
        end
      end
      1: begin
        if (memRespDrv) begin
          if (!pWr[mGrant]) mRdata[mGrant] = memRdataDrv;
          rs.port  = mGrant;
          rs.rdata = packRdata();
          rs.t     = cyc;
          expRespQ.push_back(rs);
          mState = 2;
        end
      end
      default: begin
        pend[mGrant] = 1'b0;
        mState = 0;
      end
    endcase
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      applyStimulus();
      @(posedge clk);
      modelStep();
    end
  endtask

  // downstream monitor: each new strobe must match the next expected request
  bit   prevStrobe = 1'b0;
  txn_t curTxn;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStrobe = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        checkOutput("one_strobe", 128'(mem_read & mem_write), 128'(0));
        if (!prevStrobe) begin
          if (expTxnQ.size() == 0) begin
            checkOutput("unexpected_txn", 128'(mem_address), 128'(0));
            curTxn.fields = {mem_write, mem_read, mem_byte_enable, mem_address, mem_wdata};
          end else begin
            curTxn = expTxnQ.pop_front();
            checkOutput("txn_time", 128'(cyc), 128'(curTxn.t));
          end
        end
        checkOutput("txn_fields", 128'({mem_write, mem_read, mem_byte_enable, mem_address, mem_wdata}),
                    128'(curTxn.fields));
      end
      if (expTxnQ.size() > 0 && expTxnQ[0].t < cyc) begin
        reportMiss("txn_missing", expTxnQ[0].t);
        void'(expTxnQ.pop_front());
      end
      prevStrobe = mem_read || mem_write;
    end
  end

  // response monitor: each resp pulse must match the next expected completion
  resp_t curResp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (port_resp != '0) begin
        if (expRespQ.size() == 0) begin
          checkOutput("unexpected_resp", 128'(port_resp), 128'(0));
        end else begin
          curResp = expRespQ.pop_front();
          checkOutput("resp_time", 128'(cyc), 128'(curResp.t));
          checkOutput("resp_port", 128'(port_resp), 128'(1) << curResp.port);
          checkOutput("resp_rdata", 128'(port_rdata), 128'(curResp.rdata));
          checkOutput("strobe_clear_in_resp", 128'(mem_read | mem_write), 128'(0));
        end
      end
      if (expRespQ.size() > 0 && expRespQ[0].t < cyc) begin
        reportMiss("resp_missing", expRespQ[0].t);
        void'(expRespQ.pop_front());
      end
    end
  end

  // overall time bound
  initial begin
    #2000000;
    reportMiss("watchdog", cyc);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0; pRd[i] = 1'b0; pWr[i] = 1'b0;
      pAddr[i] = '0; pBe[i] = '0; pWdata[i] = '0; mRdata[i] = '0;
    end

    // reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_read", 128'(mem_read), 128'(0));
    checkOutput("rst_mem_write", 128'(mem_write), 128'(0));
    checkOutput("rst_mem_fields", 128'({mem_byte_enable, mem_address, mem_wdata}), 128'(0));
    checkOutput("rst_port_resp", 128'(port_resp), 128'(0));
    checkOutput("rst_port_rdata", 128'(port_rdata), 128'(0));
    #2 rst_n = 1'b1;

    $display("[TB] two ports, continuous requests, immediate response");
    portMask = 3; reqPct = 100; maxLat = 0; spurPct = 0;
    runCycles(20);

    $display("[TB] three ports, continuous requests");
    portMask = 7;
    runCycles(30);

    $display("[TB] random traffic with latency and stray mem_resp");
    reqPct = 30; maxLat = 3; spurPct = 30;
    runCycles(400);

    $display("[TB] reset while a transaction is in flight");
    reqPct = 100; spurPct = 0; maxLat = 3;
    k = 0;
    while (mState != 1 && k < 50) begin
      runCycles(1);
      k++;
    end
    if (mState != 1) reportMiss("reach_busy", cyc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_resp = 1'b0;
    memRespDrv = 1'b0;
    #1;
    checkOutput("midrst_strobes", 128'({mem_read, mem_write}), 128'(0));
    checkOutput("midrst_port_resp", 128'(port_resp), 128'(0));
    checkOutput("midrst_port_rdata", 128'(port_rdata), 128'(0));
    mState = 0;
    mLast = NP - 1;
    for (int i = 0; i < NP; i++) mRdata[i] = '0;
    expRespQ.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    modelStep();

    $display("[TB] random traffic after reset");
    reqPct = 40; maxLat = 3; spurPct = 25;
    runCycles(200);

    // let outstanding requests complete
    portMask = 0;
    k = 0;
    while ((mState != 0 || anyPend()) && k < 200) begin
      runCycles(1);
      k++;
    end
    if (mState != 0 || anyPend()) reportMiss("drain", cyc);
    runCycles(3);
    checkOutput("txn_queue_empty", 128'(expTxnQ.size()), 128'(0));
    checkOutput("resp_queue_empty", 128'(expRespQ.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
